f2i: RTL
========

Name: f2i

Overview:
- Converts a bfloat16 operand (sign, 8-bit biased exponent, 7-bit mantissa) into signed fixed-point Q8.7: an 8-bit two's-complement integer part and a 7-bit fraction.
- Inverse of the fixed-to-float path in the FLOG datapath. Used wherever a float result must return to the integer/fraction domain.
- Multi-cycle: normalises by shifting one bit per clock under an FSM, then applies sign and saturation.

Parameters:
- EXP_WIDTH, 8, exponent width and integer-part width.
- MAN_WIDTH, 7, mantissa width and fraction width.
- BIAS, 127, exponent bias.
- MAX_RSHIFT, 8, right-shift cap; all magnitude bits are gone after this many shifts.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- valid_f2i_i  in  1  input operand valid.
- sgn_i  in  1  sign.
- exp_i  in  EXP_WIDTH  biased exponent.
- mantissa_i  in  MAN_WIDTH  mantissa without hidden bit.
- parte_intera  out  EXP_WIDTH  integer part, two's complement.
- parte_frazionaria  out  MAN_WIDTH  fraction bits.
- overflow_o  out  1  result saturated.
- busy_o  out  1  high whenever FSM is not IDLE.
- valid_f2i_o  out  1  one-cycle pulse, result valid.

Behaviour:
- Reset (rst=0, any time, asynchronous): FSM to IDLE, all internal registers cleared. Outputs: parte_intera=0, parte_frazionaria=0, overflow_o=0, valid_f2i_o=0, busy_o=0. Asserting reset mid-conversion aborts it and produces no valid pulse.
- Internal magnitude register mag is 15 bits in Q8.7; bit 7 has weight 1.
- IDLE
  - valid_f2i_i is sampled at the clock edge.
  - If high: capture sgn_i/exp_i/mantissa_i, load mag = {7'b0, 1'b1, mantissa_i}, go to CHECK.
  - Otherwise stay in IDLE.
- CHECK (1 cycle): classify the operand and set shift direction and count k.
  - exp==0 (zero/denormal): mag=0, k=0, go to SIGN.
  - exp==0xFF (inf/NaN), or exp>BIAS+7: overflow, go to SIGN.
  - exp==BIAS+7: in range only if sgn=1 and mantissa=0 (exactly -128.0); otherwise overflow.
  - BIAS<exp<BIAS+7: left shift, k=exp-BIAS (1..6).
  - exp<BIAS: right shift, k=min(BIAS-exp, MAX_RSHIFT).
  - exp==BIAS: k=0.
  - k=0 → SIGN; otherwise → SHIFT.
- SHIFT: one 1-bit shift of mag per cycle, logical, zero fill. Bits shifted out on the right are dropped (truncation toward zero of the magnitude). Decrement k; go to SIGN after the last shift.
- SIGN (1 cycle): at its closing edge, register the outputs and set valid_f2i_o=1.
  - Overflow: sgn=0 → parte_intera=0x7F, parte_frazionaria=0x7F, overflow_o=1. sgn=1 → 0x80/0x00, overflow_o=1.
  - -128.0 case: 0x80/0x00, overflow_o=0.
  - Normal: {parte_intera, parte_frazionaria} = sgn ? (~mag+1) : mag, 15-bit wrap.
  - Zero magnitude with sgn=1 gives 0/0 (no negative zero).
  - Then go to DONE.
- DONE (1 cycle): valid_f2i_o high this cycle only; go to IDLE.
- Latency: valid_f2i_o is high in the cycle after edge (2+k), counting the accepting edge as edge 0. This gives 2 for zero/overflow/exp==BIAS, 3..8 for left shifts, 3..10 for right shifts.
- Output holding: outputs keep their value until the next SIGN state. overflow_o updates together with the data.
- Handshake: valid_f2i_i is ignored whenever busy_o=1, including DONE. A new operand is accepted on the first IDLE cycle, so back-to-back throughput is one operand per (k+4) cycles.

Test Plan:
- 1.0 (sgn0, exp 0x7F, man 0x00) → parte_intera 0x01, parte_frazionaria 0x00, overflow 0, valid 2 edges after accept.
- 3.5 (sgn0, exp 0x80, man 0x60) → 0x03/0x40, valid 3 edges after accept; -0.75 (sgn1, exp 0x7E, man 0x40) → 0xFF/0x20, latency 3.
- Saturation: (sgn0, exp 0x86, man 0x00) → 0x7F/0x7F, overflow 1. (sgn1, exp 0x86, man 0x00) → 0x80/0x00, overflow 0. (sgn1, exp 0xFF) → 0x80/0x00, overflow 1. Latency 2 for all three.
- Underflow/zero: (sgn0, exp 0x70, man 0x7F) → 0x00/0x00, latency 10 (k capped at 8). (sgn1, exp 0x00, man 0x55) → 0x00/0x00, latency 2.
- Busy handling: pulse valid_f2i_i again 1 cycle after accepting 0.5 (exp 0x7E, man 0x00) → second pulse ignored; exactly one valid pulse with 0x00/0x40; busy_o high from accept+1 through the DONE cycle.
- Reset mid-operation: drive rst=0 while in SHIFT → all outputs 0, busy_o 0 immediately (asynchronous); no valid pulse. After release, a fresh 1.0 conversion completes correctly.

Source files
------------

// File: rtl/f2i.sv
// rtl/f2i.sv - bfloat16 to signed Q8.7 converter, one normalising shift per clock
module f2i #(
   parameter int EXP_WIDTH  = 8,
   parameter int MAN_WIDTH  = 7,
   parameter int BIAS       = 127,
   parameter int MAX_RSHIFT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_f2i_i,
   input  logic                 sgn_i,
   input  logic [EXP_WIDTH-1:0] exp_i,
   input  logic [MAN_WIDTH-1:0] mantissa_i,
   output logic [EXP_WIDTH-1:0] parte_intera,
   output logic [MAN_WIDTH-1:0] parte_frazionaria,
   output logic                 overflow_o,
   output logic                 busy_o,
   output logic                 valid_f2i_o
);

   localparam int W = EXP_WIDTH + MAN_WIDTH;
   localparam logic [EXP_WIDTH-1:0] BIAS_E   = EXP_WIDTH'(BIAS);
   localparam logic [EXP_WIDTH-1:0] EXP_TOP  = EXP_WIDTH'(BIAS + EXP_WIDTH - 1);
   localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
   localparam logic [EXP_WIDTH-1:0] RSH_CAP  = EXP_WIDTH'(MAX_RSHIFT);

   typedef enum logic [2:0] {IDLE, CHECK, SHIFT, SIGN, DONE} state_t;

   state_t                 state_q;
   logic                   sgn_q, ovf_q, n128_q, left_q, busy_q, valid_q, ovf_out_q;
   logic [EXP_WIDTH-1:0]   exp_q, k_q, int_q;
   logic [MAN_WIDTH-1:0]   man_q, frac_q;
   logic [W-1:0]           mag_q;

   logic                   ovf_d, n128_d, left_d, zero_d;
   logic [EXP_WIDTH-1:0]   k_d, rdiff;
   logic [W-1:0]           res_d;

   // Operand classification, consumed during CHECK.
   always_comb begin
      ovf_d  = 1'b0;
      n128_d = 1'b0;
      left_d = 1'b0;
      zero_d = 1'b0;
      k_d    = '0;
      rdiff  = BIAS_E - exp_q;
      if (exp_q == '0) begin
         zero_d = 1'b1;
      end else if (exp_q == EXP_ONES || exp_q > EXP_TOP) begin
         ovf_d = 1'b1;
      end else if (exp_q == EXP_TOP) begin
         if (sgn_q && man_q == '0) n128_d = 1'b1;
         else                      ovf_d  = 1'b1;
      end else if (exp_q > BIAS_E) begin
         left_d = 1'b1;
         k_d    = exp_q - BIAS_E;
      end else if (exp_q < BIAS_E) begin
         k_d = (rdiff > RSH_CAP) ? RSH_CAP : rdiff;
      end
      res_d = sgn_q ? (~mag_q + W'(1)) : mag_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         sgn_q     <= 1'b0;
         exp_q     <= '0;
         man_q     <= '0;
         mag_q     <= '0;
         k_q       <= '0;
         ovf_q     <= 1'b0;
         n128_q    <= 1'b0;
         left_q    <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         ovf_out_q <= 1'b0;
         int_q     <= '0;
         frac_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               valid_q <= 1'b0;
               if (valid_f2i_i) begin
                  sgn_q   <= sgn_i;
                  exp_q   <= exp_i;
                  man_q   <= mantissa_i;
                  mag_q   <= {{(EXP_WIDTH-1){1'b0}}, 1'b1, mantissa_i};
                  busy_q  <= 1'b1;
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               ovf_q  <= ovf_d;
               n128_q <= n128_d;
               left_q <= left_d;
               k_q    <= k_d;
               if (zero_d) mag_q <= '0;
               state_q <= (k_d == '0) ? SIGN : SHIFT;
            end
            SHIFT: begin
               mag_q <= left_q ? (mag_q << 1) : (mag_q >> 1);
               k_q   <= k_q - EXP_WIDTH'(1);
               if (k_q == EXP_WIDTH'(1)) state_q <= SIGN;
            end
            SIGN: begin
               if (ovf_q) begin
                  int_q     <= sgn_q ? {1'b1, {(EXP_WIDTH-1){1'b0}}} : {1'b0, {(EXP_WIDTH-1){1'b1}}};
                  frac_q    <= sgn_q ? '0 : '1;
                  ovf_out_q <= 1'b1;
               end else if (n128_q) begin
                  int_q     <= {1'b1, {(EXP_WIDTH-1){1'b0}}};
                  frac_q    <= '0;
                  ovf_out_q <= 1'b0;
               end else begin
                  {int_q, frac_q} <= res_d;
                  ovf_out_q       <= 1'b0;
               end
               valid_q <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign parte_intera      = int_q;
   assign parte_frazionaria = frac_q;
   assign overflow_o        = ovf_out_q;
   assign busy_o            = busy_q;
   assign valid_f2i_o       = valid_q;

endmodule
